seq_multiplier_param: RTL

//  Parametrised multi-cycle shift-add multiplier, successor to the fixed 32-bit sequential multiplier.

---
 rtl/seq_multiplier_param.sv | 99 +++++++++
 1 files changed

// File: rtl/seq_multiplier_param.sv
// Shift-add multiplier, one partial product per cycle; done pulses WIDTH+1 cycles after an accepted start.
// No queueing: start is ignored while busy, and operands are captured only on acceptance.
module seq_multiplier_param #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 w_last;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH-1:0]     w_mag2;

  // In signed mode the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
  assign w_mag1 = (signed_mode && in1[WIDTH-1]) ? -in1 : in1;
  assign w_mag2 = (signed_mode && in2[WIDTH-1]) ? -in2 : in2;
  assign w_last = (r_cnt == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_neg    <= signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_prod <= r_neg ? -r_acc : r_acc;
          end else begin
            // r_mcand is pre-shifted each cycle, so it always equals mcand << cnt.
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign prod = r_prod;

endmodule
